// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port A, load/store port B and the shared memory port.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int WORDSIZE = 64
);
  logic                a_req;
  logic [WORDSIZE-1:0] a_addr;
  logic                a_gnt;
  logic                a_rvalid;
  logic                b_req;
  logic [WORDSIZE-1:0] b_addr;
  logic                b_we;
  logic [WORDSIZE-1:0] b_wdata;
  logic                b_gnt;
  logic                b_rvalid;
  logic [WORDSIZE-1:0] rdata;
  logic                mem_req;
  logic [WORDSIZE-1:0] mem_addr;
  logic                mem_we;
  logic [WORDSIZE-1:0] mem_wdata;
  logic                mem_ready;
  logic                mem_rvalid;
  logic [WORDSIZE-1:0] mem_rdata;
  logic                busy;

  modport slave (
    input  a_req, a_addr, b_req, b_addr, b_we, b_wdata, mem_ready, mem_rvalid, mem_rdata,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, mem_req, mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output a_req, a_addr, b_req, b_addr, b_we, b_wdata, mem_ready, mem_rvalid, mem_rdata,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, mem_req, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch A / LSU B) arbiter onto a single memory port, one transaction in flight.
// ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise B has fixed priority over A.
module mem_port_arbiter #(
  parameter int WORDSIZE = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = port B owns the transaction
  logic [WORDSIZE-1:0] addr_q, addr_d;
  logic [WORDSIZE-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                any_req, pick_b, grant, resp;

  assign any_req = bus.a_req | bus.b_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q;

  // On a tie, whoever did not win the previous grant goes next.
  assign pick_b = bus.b_req & (~bus.a_req | ~last_owner_q);

  always_ff @(posedge clk) begin
    if (reset)      last_owner_q <= 1'b1;
    else if (grant) last_owner_q <= pick_b;
  end
`else
  assign pick_b = bus.b_req;
`endif

  assign grant = (state_q == IDLE) & any_req & ~reset;
  assign resp  = (state_q == WAIT) & bus.mem_rvalid & ~reset;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)        state_d = ISSUE;
      ISSUE:   if (bus.mem_ready)  state_d = WAIT;
      WAIT:    if (bus.mem_rvalid) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.a_gnt     = grant & ~pick_b;
    bus.b_gnt     = grant & pick_b;
    bus.a_rvalid  = resp & ~owner_q;
    bus.b_rvalid  = resp & owner_q;
    bus.rdata     = resp ? bus.mem_rdata : '0;
    bus.mem_req   = (state_q == ISSUE);
    bus.mem_addr  = addr_q;
    bus.mem_we    = we_q;
    bus.mem_wdata = wdata_q;
    bus.busy      = (state_q != IDLE);
  end

  // Request fields are captured once at grant and held for the whole transaction.
  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    if (grant) begin
      owner_d = pick_b;
      addr_d  = pick_b ? bus.b_addr : bus.a_addr;
      we_d    = pick_b & bus.b_we;
      wdata_d = pick_b ? bus.b_wdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
// Honors ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WORDSIZE(W)) bus ();
  mem_port_arbiter #(.WORDSIZE(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: one outstanding transaction, issued once accepted by memory
  bit         m_busy, m_sent, m_owner_b, m_last_b;
  logic [W-1:0] m_addr, m_wdata;
  bit         m_we;

  // environment state
  int  cyc = 0;
  bit  saw_b_gnt, saw_b_rv;
  int  gq[$];
  bit  mem_acc, mem_rnd;
  int  mem_dly;
  bit  a_pend, b_pend;

  task automatic check_and_model();
    bit ea, eb, resp;
    logic [W-1:0] erd;
    ea = 0; eb = 0; resp = 0; erd = '0;
    saw_b_gnt = bus.b_gnt;
    saw_b_rv  = bus.b_rvalid;
    if (bus.a_gnt) gq.push_back(0);
    if (bus.b_gnt) gq.push_back(1);
    if (bus.mem_req && bus.mem_ready && !reset) begin
      mem_acc = 1;
      mem_dly = mem_rnd ? $urandom_range(2) : 0;
    end
    if (reset) begin
      chk("a_gnt_rst", bus.a_gnt, 0);
      chk("b_gnt_rst", bus.b_gnt, 0);
      chk("a_rvalid_rst", bus.a_rvalid, 0);
      chk("b_rvalid_rst", bus.b_rvalid, 0);
      chk("rdata_rst", bus.rdata, 0);
      m_busy = 0; m_sent = 0; m_last_b = 1; m_owner_b = 0;
      m_addr = '0; m_wdata = '0; m_we = 0;
      return;
    end
    if (!m_busy) begin
      if (bus.a_req && bus.b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (m_last_b) ea = 1; else eb = 1;
`else
        eb = 1;
`endif
      end else begin
        ea = bus.a_req;
        eb = bus.b_req;
      end
    end
    resp = m_busy && m_sent && bus.mem_rvalid;
    if (resp) erd = bus.mem_rdata;
    chk("a_gnt", bus.a_gnt, ea);
    chk("b_gnt", bus.b_gnt, eb);
    chk("mem_req", bus.mem_req, m_busy && !m_sent);
    chk("busy", bus.busy, m_busy);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_we", bus.mem_we, m_we);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("a_rvalid", bus.a_rvalid, resp && !m_owner_b);
    chk("b_rvalid", bus.b_rvalid, resp && m_owner_b);
    chk("rdata", bus.rdata, erd);
    if (ea || eb) begin
      m_busy = 1; m_sent = 0; m_owner_b = eb; m_last_b = eb;
      m_addr  = eb ? bus.b_addr : bus.a_addr;
      m_we    = eb && bus.b_we;
      m_wdata = eb ? bus.b_wdata : '0;
    end else if (m_busy && !m_sent && bus.mem_ready) begin
      m_sent = 1;
    end else if (resp) begin
      m_busy = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    check_and_model();
    if (bus.a_gnt) a_pend = 0;
    if (bus.b_gnt) b_pend = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.a_req = 0; bus.a_addr = '0;
    bus.b_req = 0; bus.b_addr = '0; bus.b_we = 0; bus.b_wdata = '0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 64'hBAD0;
  endtask

  task automatic mem_auto();
    if (mem_acc && mem_dly == 0) begin
      bus.mem_rvalid = 1;
      mem_acc = 0;
    end else begin
      if (mem_acc) mem_dly--;
      bus.mem_rvalid = mem_rnd && !mem_acc && ($urandom_range(7) == 0);
    end
    bus.mem_rdata = {$urandom, $urandom};
    bus.mem_ready = mem_rnd ? 1'($urandom_range(1)) : 1'b1;
  endtask

  int exp_o[4];
  int gcnt, first_rv, second_g;
  logic [W-1:0] a_addr_r, b_addr_r, b_wdata_r;
  bit b_we_r;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_o = '{0, 1, 0, 1};
`else
    exp_o = '{1, 1, 1, 1};
`endif
    reset = 1;
    idle_in();
    cycle(); cycle();
    reset = 0;
    idle_in(); cycle();

    // A read with minimum latency
    idle_in(); bus.a_req = 1; bus.a_addr = 64'h1000; cycle();
    idle_in(); bus.mem_ready = 1; cycle();
    idle_in(); bus.mem_rvalid = 1; bus.mem_rdata = 64'hDEAD; cycle();
    idle_in(); cycle();

    // B write with memory stalling 3 cycles
    idle_in(); bus.b_req = 1; bus.b_addr = 64'h2000; bus.b_we = 1; bus.b_wdata = 64'h55; cycle();
    idle_in(); for (int i = 0; i < 3; i++) cycle();
    bus.mem_ready = 1; cycle();
    idle_in(); cycle();
    bus.mem_rvalid = 1; bus.mem_rdata = 64'h0; cycle();
    idle_in(); cycle();

    // spurious mem_rvalid in IDLE and ISSUE
    idle_in(); bus.mem_rvalid = 1; bus.mem_rdata = 64'h1111; cycle();
    idle_in(); bus.b_req = 1; bus.b_addr = 64'h2000; cycle();
    idle_in(); bus.mem_rvalid = 1; bus.mem_rdata = 64'h2222; cycle();
    idle_in(); bus.mem_ready = 1; cycle();
    idle_in(); bus.mem_rvalid = 1; bus.mem_rdata = 64'h3333; cycle();
    idle_in(); cycle();

    // reset while waiting for the response, then a late response
    idle_in(); bus.a_req = 1; bus.a_addr = 64'h6000; cycle();
    idle_in(); bus.mem_ready = 1; cycle();
    idle_in(); cycle();
    reset = 1; cycle();
    reset = 0; idle_in(); bus.mem_rvalid = 1; bus.mem_rdata = 64'h77; cycle();
    idle_in(); bus.a_req = 1; bus.a_addr = 64'h7000; cycle();
    idle_in(); bus.mem_ready = 1; cycle();
    idle_in(); bus.mem_rvalid = 1; bus.mem_rdata = 64'h88; cycle();
    idle_in(); cycle();

    // both ports requesting continuously
    reset = 1; idle_in(); cycle(); reset = 0;
    gq.delete(); mem_acc = 0; mem_rnd = 0;
    for (int i = 0; i < 60 && gq.size() < 4; i++) begin
      bus.a_req = 1; bus.a_addr = 64'h3000;
      bus.b_req = 1; bus.b_addr = 64'h4000; bus.b_we = 0; bus.b_wdata = '0;
      mem_auto(); cycle();
    end
    chk("arb_count", gq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("arb_order%0d", i), (i < gq.size()) ? gq[i] : 2, exp_o[i]);
    bus.a_req = 0; bus.b_req = 0;
    for (int i = 0; i < 8; i++) begin mem_auto(); cycle(); end

    // back-to-back B: regrant exactly one cycle after the response
    gcnt = 0; first_rv = -1; second_g = -1;
    for (int i = 0; i < 40 && second_g < 0; i++) begin
      bus.b_req = 1; bus.b_addr = 64'h5000; bus.b_we = 0;
      mem_auto(); cycle();
      if (saw_b_rv && first_rv < 0) first_rv = cyc;
      if (saw_b_gnt) begin
        gcnt++;
        if (gcnt == 2) second_g = cyc;
      end
    end
    chk("b2b_gap", second_g - first_rv, 1);
    bus.b_req = 0;
    for (int i = 0; i < 8; i++) begin mem_auto(); cycle(); end

    // randomized traffic with occasional reset
    mem_rnd = 1; mem_acc = 0; a_pend = 0; b_pend = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!a_pend && $urandom_range(2) == 0) begin
        a_pend = 1; a_addr_r = {$urandom, $urandom};
      end
      if (!b_pend && $urandom_range(2) == 0) begin
        b_pend = 1; b_addr_r = {$urandom, $urandom};
        b_we_r = 1'($urandom_range(1)); b_wdata_r = {$urandom, $urandom};
      end
      bus.a_req = a_pend; bus.a_addr = a_addr_r;
      bus.b_req = b_pend; bus.b_addr = b_addr_r; bus.b_we = b_we_r; bus.b_wdata = b_wdata_r;
      reset = ($urandom_range(199) == 0);
      mem_auto();
      cycle();
    end
    reset = 0; bus.a_req = 0; bus.b_req = 0; a_pend = 0; b_pend = 0;
    for (int i = 0; i < 10; i++) begin mem_auto(); cycle(); end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
